// File: rtl/impulse_playback_pkg.sv
// Shared audio-domain definitions for the impulse-response recorder/player pair.
package impulse_playback_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_DATA = 2'd2,
    STREAM    = 2'd3
  } state_t;

  // Stored IR length; the recorder writes exactly this many samples.
  localparam logic [15:0] IMPULSE_LENGTH_DEF = 16'd24000;

endpackage

// File: rtl/ir_fetch_latency.sv
// Down-counter covering IR memory read latency; done is high once the count has drained.
module ir_fetch_latency #(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= CNT_W'(READ_LATENCY);
    else if (en && cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/impulse_playback.sv
// Streams a stored impulse response out of IR memory, one sample per audio_trigger,
// prefetching each sample so it is staged ahead of the next sample strobe.
module impulse_playback
  import impulse_playback_pkg::*;
#(
  parameter logic [15:0] IMPULSE_LENGTH = IMPULSE_LENGTH_DEF,
  parameter int          READ_LATENCY   = 2
) (
  input  logic               audio_clk,
  input  logic               rst_in_n,
  input  logic               audio_trigger,
  input  logic               play_trigger,
  input  logic               abort_in,
  input  logic               ir_ready,
  output logic [15:0]        read_addr,
  output logic               read_enable,
  input  logic signed [15:0] read_data,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               playing,
  output logic               playback_done,
  output logic               underrun
);

  localparam logic [15:0] LAST_IDX = IMPULSE_LENGTH - 16'd1;

  state_t             state, state_nxt;
  logic [15:0]        index;
  logic signed [15:0] staged;
  logic               lat_done;
  logic               do_start, do_fetch, do_stage, do_emit, do_last, do_uflow, do_abort;

  ir_fetch_latency #(.READ_LATENCY(READ_LATENCY)) u_lat (
    .clk   (audio_clk),
    .rst_n (rst_in_n),
    .load  (do_fetch),
    .en    (state == WAIT_DATA),
    .done  (lat_done)
  );

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Abort outranks everything once busy; in IDLE a simultaneous play wins.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_fetch  = 1'b0;
    do_stage  = 1'b0;
    do_emit   = 1'b0;
    do_last   = 1'b0;
    do_uflow  = 1'b0;
    do_abort  = 1'b0;
    if (state != IDLE && abort_in) begin
      do_abort  = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (play_trigger && ir_ready) begin
          do_start  = 1'b1;
          state_nxt = FETCH;
        end
        FETCH: begin
          do_fetch  = 1'b1;
          do_uflow  = audio_trigger;
          state_nxt = WAIT_DATA;
        end
        WAIT_DATA: begin
          do_uflow = audio_trigger;
          if (lat_done) begin
            do_stage  = 1'b1;
            state_nxt = STREAM;
          end
        end
        STREAM: if (audio_trigger) begin
          do_emit = 1'b1;
          if (index == LAST_IDX) begin
            do_last   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = FETCH;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      index         <= '0;
      staged        <= '0;
      read_addr     <= '0;
      read_enable   <= 1'b0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      playing       <= 1'b0;
      playback_done <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      read_enable   <= do_fetch;
      sample_valid  <= do_emit | do_uflow;
      playback_done <= do_last;
      if (state == IDLE) sample_out <= '0;
      if (do_start) begin
        index    <= '0;
        underrun <= 1'b0;
        playing  <= 1'b1;
      end
      if (do_fetch) read_addr <= index;
      if (do_stage) staged    <= read_data;
      // A strobe that beats the fetch outputs silence; the fetch keeps going.
      if (do_uflow) begin
        underrun   <= 1'b1;
        sample_out <= '0;
      end
      if (do_emit) begin
        sample_out <= staged;
        if (!do_last) index <= index + 16'd1;
      end
      if (do_last) playing <= 1'b0;
      if (do_abort) begin
        playing    <= 1'b0;
        sample_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_impulse_playback.sv
// Drives three players (read latency 2, 1, 4) in lockstep against a timing-arithmetic model.
module tb_impulse_playback;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{2, 1, 4};
  localparam int LEN = 8;

  logic audio_clk = 1'b0;
  logic rst_in_n  = 1'b1;
  logic audio_trigger = 1'b0, play_trigger = 1'b0, abort_in = 1'b0, ir_ready = 1'b0;

  logic [15:0]        read_addr     [NDUT];
  logic               read_enable   [NDUT];
  logic signed [15:0] read_data     [NDUT];
  logic signed [15:0] sample_out    [NDUT];
  logic               sample_valid  [NDUT];
  logic               playing       [NDUT];
  logic               playback_done [NDUT];
  logic               underrun      [NDUT];

  logic signed [15:0] mem [LEN];

  always #5 audio_clk = ~audio_clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = LAT[g];
    logic [15:0] pa [4];
    logic        pv [4];

    impulse_playback #(.IMPULSE_LENGTH(16'(LEN)), .READ_LATENCY(L)) u_dut (
      .audio_clk     (audio_clk),
      .rst_in_n      (rst_in_n),
      .audio_trigger (audio_trigger),
      .play_trigger  (play_trigger),
      .abort_in      (abort_in),
      .ir_ready      (ir_ready),
      .read_addr     (read_addr[g]),
      .read_enable   (read_enable[g]),
      .read_data     (read_data[g]),
      .sample_out    (sample_out[g]),
      .sample_valid  (sample_valid[g]),
      .playing       (playing[g]),
      .playback_done (playback_done[g]),
      .underrun      (underrun[g])
    );

    // Memory returns data for exactly one cycle, L cycles after the read strobe.
    always @(posedge audio_clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
        for (int k = 0; k < 4; k++) begin pv[k] <= 1'b0; pa[k] <= '0; end
      end else begin
        pv[0] <= read_enable[g];
        pa[0] <= read_addr[g];
        for (int k = 1; k < 4; k++) begin pv[k] <= pv[k-1]; pa[k] <= pa[k-1]; end
      end
    end
    assign read_data[g] = pv[L-1] ? mem[pa[L-1][2:0]] : 16'sd0;
  end

  int vectors = 0, miscompares = 0, cyc = 0;

  // Model: a session is busy with a current index and the cycle its sample gets staged.
  bit                 m_busy  [NDUT];
  bit                 m_valid [NDUT];
  bit                 m_done  [NDUT];
  bit                 m_und   [NDUT];
  bit                 m_re    [NDUT];
  int                 m_idx   [NDUT];
  int                 m_stage [NDUT];
  logic signed [15:0] m_out   [NDUT];

  task automatic reset_model();
    for (int g = 0; g < NDUT; g++) begin
      m_busy[g] = 0; m_valid[g] = 0; m_done[g] = 0; m_und[g] = 0; m_re[g] = 0;
      m_idx[g] = 0; m_stage[g] = 0; m_out[g] = '0;
    end
  endtask

  task automatic model_edge();
    if (!rst_in_n) begin
      reset_model();
      return;
    end
    for (int g = 0; g < NDUT; g++) begin
      m_valid[g] = 0;
      m_done[g]  = 0;
      if (!m_busy[g]) begin
        m_out[g] = '0;
        if (play_trigger && ir_ready) begin
          m_busy[g] = 1; m_idx[g] = 0; m_und[g] = 0; m_stage[g] = cyc + LAT[g] + 2;
        end
      end else if (abort_in) begin
        m_busy[g] = 0;
        m_out[g]  = '0;
      end else if (audio_trigger) begin
        m_valid[g] = 1;
        if (cyc > m_stage[g]) begin
          m_out[g] = mem[m_idx[g]];
          if (m_idx[g] == LEN - 1) begin
            m_busy[g] = 0;
            m_done[g] = 1;
          end else begin
            m_idx[g]++;
            m_stage[g] = cyc + LAT[g] + 2;
          end
        end else begin
          m_out[g] = '0;
          m_und[g] = 1;
        end
      end
      m_re[g] = m_busy[g] && (cyc == m_stage[g] - LAT[g] - 1);
    end
  endtask

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[lat%0d] cyc=%0d observed=%0h expected=%0h", tag, LAT[g], cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NDUT; g++) begin
      chk("sample_valid",  g, 32'(sample_valid[g]),  32'(m_valid[g]));
      chk("sample_out",    g, 32'(sample_out[g]),    32'(m_out[g]));
      chk("playing",       g, 32'(playing[g]),       32'(m_busy[g]));
      chk("playback_done", g, 32'(playback_done[g]), 32'(m_done[g]));
      chk("underrun",      g, 32'(underrun[g]),      32'(m_und[g]));
      chk("read_enable",   g, 32'(read_enable[g]),   32'(m_re[g]));
      if (m_re[g]) chk("read_addr", g, 32'(read_addr[g]), 32'(m_idx[g]));
    end
  endtask

  task automatic tick();
    @(posedge audio_clk);
    cyc++;
    model_edge();
    #1;
    check_all();
    play_trigger  = 1'b0;
    abort_in      = 1'b0;
    audio_trigger = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic play();
    play_trigger = 1'b1;
    tick();
  endtask

  task automatic trig_every(input int n, input int gap);
    repeat (n) begin
      idle(gap - 1);
      audio_trigger = 1'b1;
      tick();
    end
  endtask

  // Assert reset between clock edges and check outputs before any edge arrives.
  task automatic async_reset();
    #2;
    rst_in_n = 1'b0;
    #1;
    reset_model();
    check_all();
    idle(2);
    #2;
    rst_in_n = 1'b1;
  endtask

  initial begin
    reset_model();
    for (int i = 0; i < LEN; i++) mem[i] = 16'(i - 100);
    #1;
    async_reset();

    // Basic run with an ignored second play mid-stream.
    ir_ready = 1'b1;
    play();
    trig_every(3, 50);
    play();
    trig_every(6, 50);
    idle(10);

    // Play without a stored IR is ignored.
    ir_ready = 1'b0;
    play();
    idle(20);
    ir_ready = 1'b1;

    // Abort after the third sample, then a fresh run from address 0.
    play();
    trig_every(3, 50);
    idle(5);
    abort_in = 1'b1;
    tick();
    idle(60);
    play();
    trig_every(9, 50);

    // Abort while a read is in flight.
    play();
    tick();
    abort_in = 1'b1;
    tick();
    idle(20);

    // Abort coinciding with the final trigger.
    play();
    trig_every(7, 50);
    idle(49);
    audio_trigger = 1'b1;
    abort_in      = 1'b1;
    tick();
    idle(10);

    // Underrun: trigger one cycle after play, with fresh memory contents.
    for (int i = 0; i < LEN; i++) mem[i] = 16'($urandom);
    play();
    audio_trigger = 1'b1;
    tick();
    trig_every(9, 50);

    // Reset mid-stream, then a clean restart.
    play();
    trig_every(2, 50);
    idle(20);
    async_reset();
    play();
    trig_every(9, 50);
    idle(5);

    // Random strobes, readiness and aborts.
    for (int c = 0; c < 4000; c++) begin
      ir_ready      = ($urandom_range(0, 9) != 0);
      play_trigger  = ($urandom_range(0, 59) == 0);
      abort_in      = ($urandom_range(0, 399) == 0);
      audio_trigger = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
